// File: rtl/echo_pkg.sv
// ============================================================================
// Module      : echo_pkg
// Description : Shared FSM encoding and saturation helpers for axis_echo_delay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package echo_pkg;

    localparam int ECHO_DATA_WIDTH = 24;

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_RECV_L = 3'd1,
        S_RECV_R = 3'd2,
        S_READ   = 3'd3,
        S_MIX    = 3'd4,
        S_SEND_L = 3'd5,
        S_SEND_R = 3'd6
    } echo_state_t;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int SAT_MAX = sat_max(ECHO_DATA_WIDTH);
    localparam int SAT_MIN = sat_min(ECHO_DATA_WIDTH);

endpackage

`default_nettype wire

// File: rtl/axis_echo_delay_if.sv
// ============================================================================
// Module      : axis_echo_delay_if
// Description : AXI-Stream sample channel (data/valid/ready/last) with modports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_echo_delay_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

`default_nettype wire

// File: rtl/echo_delay_ram.sv
// ============================================================================
// Module      : echo_delay_ram
// Description : Simple dual-port frame buffer, synchronous 1-cycle read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module echo_delay_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 12
) (
    input  wire logic                    clk,
    input  wire logic                    i_we,
    input  wire logic [ADDR_WIDTH-1:0]   i_waddr,
    input  wire logic [2*DATA_WIDTH-1:0] i_wdata,
    input  wire logic                    i_re,
    input  wire logic [ADDR_WIDTH-1:0]   i_raddr,
    output logic      [2*DATA_WIDTH-1:0] o_rdata
);
    logic [2*DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [2*DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

`default_nettype wire

// File: rtl/axis_echo_delay.sv
// ============================================================================
// Module      : axis_echo_delay
// Description : Stereo AXI-Stream echo: mixes each frame with an attenuated,
//               delayed frame from a circular buffer, with saturation.
//               ECHO_FEEDBACK_EN: buffer stores the mixed output (recirculating).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_echo_delay
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH  = ECHO_DATA_WIDTH,
    parameter int ADDR_WIDTH  = 12,
    parameter int DECAY_WIDTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   resetn,
    input  wire logic [ADDR_WIDTH-1:0]  delay,
    input  wire logic [DECAY_WIDTH-1:0] decay,
    axis_echo_delay_if.slave            s_axis,
    axis_echo_delay_if.master           m_axis
);
    localparam logic signed [DATA_WIDTH:0] c_SAT_MAX = (DATA_WIDTH+1)'(sat_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH:0] c_SAT_MIN = (DATA_WIDTH+1)'(sat_min(DATA_WIDTH));
    localparam int                         c_PW      = DATA_WIDTH + DECAY_WIDTH + 1;

    echo_state_t                    r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]          r_clr_addr, r_wr_ptr, r_delay;
    logic [DECAY_WIDTH-1:0]         r_decay;
    logic signed [DATA_WIDTH-1:0]   r_in_l, r_in_r, r_mix_r, r_m_data;
    logic signed [DATA_WIDTH-1:0]   w_wet_l, w_wet_r, w_mix_l, w_mix_r;
    logic [2*DATA_WIDTH-1:0]        w_rdata, w_store, w_wdata;
    logic [ADDR_WIDTH-1:0]          w_waddr, w_raddr;
    logic                           w_we, w_re;

    function automatic logic signed [DATA_WIDTH-1:0] f_mix(
        input logic signed [DATA_WIDTH-1:0] dry,
        input logic signed [DATA_WIDTH-1:0] wet,
        input logic [DECAY_WIDTH-1:0]       gain
    );
        logic signed [c_PW-1:0]     prod;
        logic signed [DATA_WIDTH:0] sum;
        prod = c_PW'(wet) * c_PW'($signed({1'b0, gain}));
        prod = prod >>> DECAY_WIDTH;
        // gain < 1, so the scaled echo always fits in DATA_WIDTH+1 bits
        sum  = $signed({dry[DATA_WIDTH-1], dry}) + $signed(prod[DATA_WIDTH:0]);
        if (sum > c_SAT_MAX) begin
            return c_SAT_MAX[DATA_WIDTH-1:0];
        end else if (sum < c_SAT_MIN) begin
            return c_SAT_MIN[DATA_WIDTH-1:0];
        end
        return sum[DATA_WIDTH-1:0];
    endfunction

    assign w_wet_l = w_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_wet_r = w_rdata[DATA_WIDTH-1:0];
    assign w_mix_l = (r_delay == '0) ? r_in_l : f_mix(r_in_l, w_wet_l, r_decay);
    assign w_mix_r = (r_delay == '0) ? r_in_r : f_mix(r_in_r, w_wet_r, r_decay);

`ifdef ECHO_FEEDBACK_EN
    assign w_store = {w_mix_l, w_mix_r};
`else
    assign w_store = {r_in_l, r_in_r};
`endif

    assign w_we    = (r_state == S_CLEAR) || (r_state == S_MIX);
    assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr : r_wr_ptr;
    assign w_wdata = (r_state == S_CLEAR) ? '0 : w_store;
    assign w_re    = (r_state == S_READ);
    assign w_raddr = r_wr_ptr - r_delay;

    echo_delay_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR:  if (r_clr_addr == '1) w_state_nxt = S_RECV_L;
            S_RECV_L: if (s_axis.valid && !s_axis.last) w_state_nxt = S_RECV_R;
            S_RECV_R: if (s_axis.valid && s_axis.last) w_state_nxt = S_READ;
            S_READ:   w_state_nxt = S_MIX;
            S_MIX:    w_state_nxt = S_SEND_L;
            S_SEND_L: if (m_axis.ready) w_state_nxt = S_SEND_R;
            S_SEND_R: if (m_axis.ready) w_state_nxt = S_RECV_L;
            default:  w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clr_addr <= '0;
            r_wr_ptr   <= '0;
            r_delay    <= '0;
            r_decay    <= '0;
            r_in_l     <= '0;
            r_in_r     <= '0;
            r_mix_r    <= '0;
            r_m_data   <= '0;
        end else begin
            case (r_state)
                S_CLEAR: r_clr_addr <= r_clr_addr + 1'b1;
                S_RECV_L: begin
                    // delay/decay are sampled once per frame, on the left beat
                    if (s_axis.valid && !s_axis.last) begin
                        r_in_l  <= s_axis.data;
                        r_delay <= delay;
                        r_decay <= decay;
                    end
                end
                S_RECV_R: begin
                    if (s_axis.valid) begin
                        if (s_axis.last) r_in_r <= s_axis.data;
                        else             r_in_l <= s_axis.data;
                    end
                end
                S_MIX: begin
                    r_m_data <= w_mix_l;
                    r_mix_r  <= w_mix_r;
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                S_SEND_L: if (m_axis.ready) r_m_data <= r_mix_r;
                default: ;
            endcase
        end
    end

    assign s_axis.ready = (r_state == S_RECV_L) || (r_state == S_RECV_R);
    assign m_axis.valid = (r_state == S_SEND_L) || (r_state == S_SEND_R);
    assign m_axis.last  = (r_state == S_SEND_R);
    assign m_axis.data  = r_m_data;
endmodule

`default_nettype wire
